// File: rtl/bias_ctrl.sv
// Bias channel controller: pops 16-bit opcodes from the bias FIFO, updates a
// shadow on/off mask for up to NUM_CH PA bias channels, and ships each new
// mask to the SPI data FIFO as one command byte followed by the mask bytes
// (most significant first). Each frame is followed by one request byte on
// the SPI request queue. Every wait on a full or ack input is bounded by
// ACK_TIMEOUT cycles. The committed mask only changes when a whole frame
// has been handed off.
module bias_ctrl #(
  parameter int         NUM_CH      = 16,
  parameter int         S4_CH       = 4,
  parameter logic [7:0] CMD_BYTE    = 8'h40,
  parameter logic [7:0] QUEUE_ID    = 8'h05,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bias_en,
  input  logic              x7_mode,
  input  logic [15:0]       bias_fifo_i,
  output logic              bias_fifo_rd_en_o,
  input  logic              bias_fifo_empty_i,
  output logic [7:0]        spi_o,
  output logic              spi_wr_en_o,
  input  logic              spi_fifo_full_i,
  input  logic              spi_wr_ack_i,
  output logic [7:0]        spiwr_queue_data_o,
  output logic              spiwr_queue_wr_en_o,
  input  logic              spiwr_queue_fifo_full_i,
  input  logic              spiwr_queue_wr_ack_i,
  output logic [NUM_CH-1:0] bias_state_o,
  output logic [7:0]        status_o,
  output logic              busy_o
);

  localparam int MB = (NUM_CH + 7) / 8;
  localparam int IW = $clog2(MB + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(MB);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [8:0]    LIM_X7   = 9'(NUM_CH);
  localparam logic [8:0]    LIM_S4   = 9'(S4_CH);

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ERR_CH  = 8'h31;
  localparam logic [7:0] ST_ERR_OP  = 8'h32;
  localparam logic [7:0] ST_ERR_TMO = 8'h33;

  localparam logic [1:0] OP_SET_CH  = 2'b00;
  localparam logic [1:0] OP_ALL_OFF = 2'b01;
  localparam logic [1:0] OP_ALL_ON  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_SPI_WR  = 3'd3,
    S_SPI_ACK = 3'd4,
    S_Q_WR    = 3'd5,
    S_Q_ACK   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [1:0]          op_code_r;
  logic                op_val_r;
  logic [7:0]          op_ch_r;
  logic [NUM_CH-1:0]   next_mask_r;
  logic [NUM_CH-1:0]   bias_state_r;
  logic [7:0]          status_r;
  logic                busy_r;
  logic [IW-1:0]       idx_r;
  logic [TW-1:0]       tmo_cnt_r;

  logic [8:0]          lim_s;
  logic [NUM_CH-1:0]   lim_mask_s;
  logic [NUM_CH-1:0]   build_mask_s;
  logic [MB*8-1:0]     pad_mask_s;
  logic                err_op_s;
  logic                err_ch_s;
  logic                tmo_hit_s;
  logic                rd_en_s;
  logic                spi_wr_en_s;
  logic [7:0]          spi_data_s;
  logic                q_wr_en_s;
  logic [7:0]          q_data_s;
  logic                unused_s;

  // Opcode bits 13:9 carry no meaning for any operation.
  assign unused_s = ^bias_fifo_i[13:9];

  // Byte idx of the frame: 0 is the command byte, 1..MB are mask bytes MSB first.
  function automatic logic [7:0] frame_byte(input logic [IW-1:0] idx,
                                            input logic [MB*8-1:0] pad);
    logic [7:0] byte_v;
    byte_v = CMD_BYTE;
    for (int k = 1; k <= MB; k++) begin
      if (idx == IW'(k)) begin
        byte_v = pad[(MB-k)*8 +: 8];
      end
    end
    return byte_v;
  endfunction

  // Channel limit, opcode checks and the candidate mask for the latched opcode.
  always_comb begin
    lim_s        = x7_mode ? LIM_X7 : LIM_S4;
    lim_mask_s   = {NUM_CH{1'b0}};
    build_mask_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      lim_mask_s[i] = (9'(i) < lim_s);
    end
    err_op_s = (op_code_r == OP_ILLEGAL);
    err_ch_s = (op_code_r == OP_SET_CH) && ({1'b0, op_ch_r} >= lim_s);
    case (op_code_r)
      OP_SET_CH: begin
        build_mask_s = bias_state_r;
        for (int i = 0; i < NUM_CH; i++) begin
          if (op_ch_r == 8'(i)) begin
            build_mask_s[i] = op_val_r;
          end else begin
            build_mask_s[i] = bias_state_r[i];
          end
        end
      end
      OP_ALL_OFF: build_mask_s = {NUM_CH{1'b0}};
      OP_ALL_ON:  build_mask_s = lim_mask_s;
      default:    build_mask_s = {NUM_CH{1'b0}};
    endcase
    build_mask_s = build_mask_s & lim_mask_s;
    pad_mask_s   = {(MB*8){1'b0}};
    pad_mask_s[NUM_CH-1:0] = next_mask_r;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic, including the bounded waits on full/ack inputs.
  always_comb begin
    state_next_s = state_r;
    tmo_hit_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bias_en && !bias_fifo_empty_i) begin
          state_next_s = S_LATCH;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LATCH: state_next_s = S_DECODE;
      S_DECODE: begin
        if (err_op_s || err_ch_s) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_SPI_WR;
        end
      end
      S_SPI_WR: begin
        if (!spi_fifo_full_i) begin
          state_next_s = S_SPI_ACK;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_next_s = S_IDLE;
          tmo_hit_s    = 1'b1;
        end else begin
          state_next_s = S_SPI_WR;
        end
      end
      S_SPI_ACK: begin
        if (spi_wr_ack_i) begin
          state_next_s = (idx_r == IDX_LAST) ? S_Q_WR : S_SPI_WR;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_next_s = S_IDLE;
          tmo_hit_s    = 1'b1;
        end else begin
          state_next_s = S_SPI_ACK;
        end
      end
      S_Q_WR: begin
        if (!spiwr_queue_fifo_full_i) begin
          state_next_s = S_Q_ACK;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_next_s = S_IDLE;
          tmo_hit_s    = 1'b1;
        end else begin
          state_next_s = S_Q_WR;
        end
      end
      S_Q_ACK: begin
        if (spiwr_queue_wr_ack_i) begin
          state_next_s = S_DONE;
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_next_s = S_IDLE;
          tmo_hit_s    = 1'b1;
        end else begin
          state_next_s = S_Q_ACK;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Strobes and data bytes; a strobe is only raised in its issuing state.
  always_comb begin
    rd_en_s     = 1'b0;
    spi_wr_en_s = 1'b0;
    spi_data_s  = 8'h00;
    q_wr_en_s   = 1'b0;
    q_data_s    = 8'h00;
    case (state_r)
      S_IDLE: begin
        rd_en_s = bias_en && !bias_fifo_empty_i && !rst;
      end
      S_SPI_WR: begin
        spi_data_s  = frame_byte(idx_r, pad_mask_s);
        spi_wr_en_s = !spi_fifo_full_i;
      end
      S_Q_WR: begin
        q_data_s  = QUEUE_ID;
        q_wr_en_s = !spiwr_queue_fifo_full_i;
      end
      default: begin
        rd_en_s = 1'b0;
      end
    endcase
  end

  // Opcode capture, frame bookkeeping, committed mask, status and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_code_r    <= 2'b00;
      op_val_r     <= 1'b0;
      op_ch_r      <= 8'h00;
      next_mask_r  <= {NUM_CH{1'b0}};
      bias_state_r <= {NUM_CH{1'b0}};
      status_r     <= ST_OK;
      busy_r       <= 1'b0;
      idx_r        <= {IW{1'b0}};
      tmo_cnt_r    <= {TW{1'b0}};
    end else begin
      case (state_r)
        S_LATCH: begin
          op_code_r <= bias_fifo_i[15:14];
          op_val_r  <= bias_fifo_i[8];
          op_ch_r   <= bias_fifo_i[7:0];
        end
        S_DECODE: begin
          if (err_op_s) begin
            status_r <= ST_ERR_OP;
          end else if (err_ch_s) begin
            status_r <= ST_ERR_CH;
          end else begin
            next_mask_r <= build_mask_s;
            idx_r       <= {IW{1'b0}};
          end
        end
        S_SPI_ACK: begin
          if (spi_wr_ack_i && (idx_r != IDX_LAST)) begin
            idx_r <= idx_r + IW'(1);
          end
        end
        S_DONE: begin
          bias_state_r <= next_mask_r;
          status_r     <= ST_OK;
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
      if (tmo_hit_s) begin
        status_r <= ST_ERR_TMO;
      end
      // Restart the wait counter on every state change.
      if (state_next_s != state_r) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
      busy_r <= (state_next_s != S_IDLE);
    end
  end

  assign bias_fifo_rd_en_o   = rd_en_s;
  assign spi_wr_en_o         = spi_wr_en_s;
  assign spi_o               = spi_data_s;
  assign spiwr_queue_wr_en_o = q_wr_en_s;
  assign spiwr_queue_data_o  = q_data_s;
  assign bias_state_o        = bias_state_r;
  assign status_o            = status_r;
  assign busy_o              = busy_r;

endmodule
